llr_input_loader_ne: RTL and testbench
======================================

// Module: llr_input_loader_ne
// PURPOSE
//  Input-side counterpart of the decoder output interface. It accepts a serial
//  stream of INDW-bit LLR beats from upstream and packs KB beats into one wide
//  word. Each word is written to the decoder LLR memory at LOADADDRESS. After
//  LOADCOUNT words it pulses load_done so the decoder core starts the frame.
// PARAMETERS
//  KB          14  beats per memory word (message block columns)
//  INDW        32  bits per input beat
//  LOADCOUNT   17  memory words per frame
//  ADDRESSWIDTH 5  width of LOADADDRESS (2^5 > LOADCOUNT)
// PORTS
//  clk          in   1          single clock; all logic posedge
//  rst          in   1          async, active-high; clears all state
//  load_start   in   1          core grants LLR memory; sampled only in IDLE
//  in_valid     in   1          upstream beat valid
//  LLR_in       in   INDW       upstream beat data
//  in_ready     out  1          beat accepted when in_valid & in_ready
//  load_en      out  1          LLR memory write enable, 1-cycle pulse per word
//  LOADADDRESS  out  ADDRESSWIDTH  write address, 0..LOADCOUNT-1
//  WRDOUT_VEC   out  KB*INDW    packed write data, beat b in [(b+1)*INDW-1:b*INDW]
//  load_done    out  1          1-cycle pulse: frame fully written
//  busy         out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset values: in_ready=0, load_en=0, LOADADDRESS=0, WRDOUT_VEC=0,
//   load_done=0, busy=0. Counters=0, state=IDLE. All outputs are registered
//   except in_ready and busy, which are decoded from the state register.
//  States: IDLE -> FILL -> FLUSH -> DONE -> IDLE.
//   IDLE : in_ready=0. On load_start=1, go to FILL; beat_cnt=0, addr_cnt=0.
//   FILL : in_ready=1. Each accepted beat goes into pack slot beat_cnt, and
//          beat_cnt increments.
//          On acceptance with beat_cnt==KB-1:
//           - copy the packed word (including this beat) into the WRDOUT_VEC hold register;
//           - next cycle: load_en=1, LOADADDRESS=addr_cnt;
//           - beat_cnt wraps to 0 and addr_cnt increments.
//          If addr_cnt==LOADCOUNT-1 at that acceptance, go to FLUSH instead of staying in FILL.
//   FLUSH: in_ready=0. This is the cycle where load_en=1 for the final address.
//          Always go to DONE.
//   DONE : load_done=1 for exactly one cycle. Return to IDLE.
//  Latency: load_en is high in the cycle after the accepting edge of the KB-th
//   beat. load_done is one cycle after the final load_en. From the first accepted
//   beat, the minimum frame time is KB*LOADCOUNT+2 cycles.
//  Back-to-back: a new beat may be accepted in the same cycle that load_en is
//   high. The hold register is separate from the pack register, so there is no stall.
//  Gaps: in_valid may drop at any beat. Counters hold and no data is lost.
//  in_valid while in_ready=0: ignored, nothing latched.
//  load_start outside IDLE: ignored. load_start in DONE: ignored, so a new frame
//   needs load_start re-asserted in IDLE.
//  WRDOUT_VEC and LOADADDRESS hold their last values between load_en pulses.
//  Async reset mid-frame: partial frame discarded. No load_en or load_done is
//   emitted for it. The block restarts from IDLE.
//  Widths: beat_cnt is clog2(KB) bits and wraps at KB-1, not at 2^n.
//   addr_cnt is ADDRESSWIDTH bits and never exceeds LOADCOUNT-1.
// STRUCTURE
//  Shared include ldpc_params_ne.vh holds KB, INDW, LOADCOUNT, ADDRESSWIDTH
//   defaults and state encodings (IDLE=0, FILL=1, FLUSH=2, DONE=3).
//  One sub-module, llr_beat_packer_ne: beat_cnt, pack register, hold register,
//   and a word_ready strobe. The parent holds the FSM, addr_cnt and output regs.
// TESTING
//  1. Frame with in_valid held high, beat value = global beat index (0..237)
//     -> 17 load_en pulses on consecutive 14-cycle boundaries;
//     -> addr 0 word has bits[31:0]=0, bits[447:416]=13;
//     -> load_done is exactly 1 cycle after addr 16's load_en.
//  2. Random in_valid gaps (~50% duty) -> same addresses and data as test 1;
//     -> load_en never fires mid-word; beat count unchanged.
//  3. in_valid=1 in IDLE before load_start -> in_ready=0, nothing latched;
//     -> after load_start, the first accepted beat lands in slot 0 of addr 0.
//  4. load_start pulsed during FILL and DONE -> no restart and no count change;
//     -> exactly one load_done per frame.
//  5. rst asserted after 100 accepted beats -> all outputs 0 asynchronously;
//     -> a new full frame then reproduces test 1 exactly.
//  6. Two frames back-to-back (load_start re-asserted in IDLE) -> addresses
//     restart at 0, 2 load_done pulses total, no stale data carried into frame 2.

Source files
------------

// File: rtl/llr_input_loader_ne_pkg.sv
// LLR input loader shared parameters and FSM state encoding.
// Imported by the beat packer and the loader top.
package llr_input_loader_ne_pkg;

  localparam int KB           = 14;
  localparam int INDW         = 32;
  localparam int LOADCOUNT    = 17;
  localparam int ADDRESSWIDTH = 5;
  localparam int BCW          = $clog2(KB);
  localparam int WW           = KB * INDW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/llr_input_loader_ne_packer.sv
// Packs KB serial beats into one word; the finished word moves to a
// separate hold register so packing the next word never stalls.
module llr_beat_packer_ne
  import llr_input_loader_ne_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            accept,
  input  logic [INDW-1:0] beat,
  output logic            word_ready,
  output logic [WW-1:0]   hold_word
);

  logic [BCW-1:0]            beat_cnt;
  logic [KB-1:0][INDW-1:0]   pack_q;
  logic [KB-1:0][INDW-1:0]   pack_d;
  logic [KB-1:0][INDW-1:0]   hold_q;
  logic                      last;

  assign last       = (beat_cnt == BCW'(KB - 1));
  assign word_ready = accept & last;
  assign hold_word  = hold_q;

  // Word including the beat being accepted this cycle
  always_comb begin
    pack_d           = pack_q;
    pack_d[beat_cnt] = beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      pack_q   <= '0;
      hold_q   <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
    end else if (accept) begin
      pack_q   <= pack_d;
      beat_cnt <= last ? '0 : beat_cnt + 1'b1;
      if (last) hold_q <= pack_d;
    end
  end

endmodule

// File: rtl/llr_input_loader_ne.sv
// LLR input loader: serial beats in, KB-beat words written to decoder
// LLR memory at consecutive addresses, load_done after the last word.
module llr_input_loader_ne
  import llr_input_loader_ne_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    in_valid,
  input  logic [INDW-1:0]         LLR_in,
  output logic                    in_ready,
  output logic                    load_en,
  output logic [ADDRESSWIDTH-1:0] LOADADDRESS,
  output logic [WW-1:0]           WRDOUT_VEC,
  output logic                    load_done,
  output logic                    busy
);

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDRESSWIDTH-1:0] addr_cnt;
  logic                    accept;
  logic                    clr;
  logic                    word_ready;
  logic                    addr_last;

  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid & in_ready;
  assign clr       = (state_q == IDLE) & load_start;
  assign addr_last = (addr_cnt == ADDRESSWIDTH'(LOADCOUNT - 1));

  llr_beat_packer_ne u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .accept     (accept),
    .beat       (LLR_in),
    .word_ready (word_ready),
    .hold_word  (WRDOUT_VEC)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_start) state_d = FILL;
      FILL:    if (word_ready && addr_last) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_cnt    <= '0;
      load_en     <= 1'b0;
      LOADADDRESS <= '0;
      load_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_en   <= word_ready;
      // High while in DONE, one cycle after the final write
      load_done <= (state_q == FLUSH);
      if (clr) begin
        addr_cnt <= '0;
      end else if (word_ready) begin
        LOADADDRESS <= addr_cnt;
        addr_cnt    <= addr_last ? '0 : addr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_llr_input_loader_ne.sv
// Scoreboard bench for llr_input_loader_ne: driver queues expected
// words, a negedge monitor checks every load_en and load_done.
module tb_llr_input_loader_ne;
  import llr_input_loader_ne_pkg::*;

  typedef struct {
    logic [ADDRESSWIDTH-1:0] addr;
    logic [WW-1:0]           data;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    load_start;
  logic                    in_valid;
  logic [INDW-1:0]         LLR_in;
  logic                    in_ready;
  logic                    load_en;
  logic [ADDRESSWIDTH-1:0] LOADADDRESS;
  logic [WW-1:0]           WRDOUT_VEC;
  logic                    load_done;
  logic                    busy;

  exp_t exp_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  int   cyc      = 0;
  int   last_en_cyc  = -100;
  int   last_en_addr = -1;
  int   frame_en = 0;
  bit   gapless  = 1'b0;

  llr_input_loader_ne dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .LLR_in      (LLR_in),
    .in_ready    (in_ready),
    .load_en     (load_en),
    .LOADADDRESS (LOADADDRESS),
    .WRDOUT_VEC  (WRDOUT_VEC),
    .load_done   (load_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [WW-1:0] act,
                     input logic [WW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every load_en must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (load_en) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_load_en", WW'(LOADADDRESS), '0);
        end else begin
          e = exp_q.pop_front();
          chk(LOADADDRESS == e.addr, "addr",
              WW'(LOADADDRESS), WW'(e.addr));
          chk(WRDOUT_VEC == e.data, "data", WRDOUT_VEC, e.data);
          if (e.addr == 0) begin
            chk(WRDOUT_VEC[31:0] == 32'd0, "a0_slot0",
                WW'(WRDOUT_VEC[31:0]), '0);
            chk(WRDOUT_VEC[447:416] == 32'd13, "a0_slot13",
                WW'(WRDOUT_VEC[447:416]), WW'(13));
          end
          if (gapless && frame_en > 0)
            chk(cyc - last_en_cyc == KB, "en_spacing",
                WW'(cyc - last_en_cyc), WW'(KB));
        end
        frame_en++;
        last_en_cyc  = cyc;
        last_en_addr = int'(LOADADDRESS);
      end
      if (load_done) begin
        chk(last_en_cyc == cyc - 1 && last_en_addr == LOADCOUNT - 1,
            "done_timing", WW'(cyc - last_en_cyc), WW'(1));
        done_cnt++;
      end
    end
  end

  task automatic run_frame(input int duty, input int abort_at,
                           input bit pulse_fill, input bit pulse_done);
    logic [WW-1:0] w;
    int g;
    int d0;
    w = '0;
    g = 0;
    d0 = done_cnt;
    gapless  = (duty == 100);
    frame_en = 0;
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    while (g < KB * LOADCOUNT) begin
      if (abort_at >= 0 && g == abort_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk({load_en, LOADADDRESS, WRDOUT_VEC, load_done,
             busy, in_ready} == '0, "async_rst",
            WW'({load_en, LOADADDRESS, load_done, busy, in_ready}), '0);
        chk(WRDOUT_VEC == '0, "rst_wrdout", WRDOUT_VEC, '0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        return;
      end
      in_valid   = ($urandom_range(99) < duty);
      LLR_in     = INDW'(g);
      load_start = pulse_fill && (g == 50);
      if (in_valid && in_ready) begin
        w[(g % KB) * INDW +: INDW] = INDW'(g);
        if (g % KB == KB - 1) begin
          exp_q.push_back('{addr: ADDRESSWIDTH'(g / KB), data: w});
        end
        g++;
      end
      @(negedge clk);
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    if (pulse_done) begin
      @(negedge clk);
      chk(load_done == 1'b1, "in_done_state", WW'(load_done), WW'(1));
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk(done_cnt == d0 + 1, "one_done_per_frame",
        WW'(done_cnt - d0), WW'(1));
    chk(busy == 1'b0, "idle_after_frame", WW'(busy), '0);
    chk(exp_q.size() == 0, "all_words_seen",
        WW'(exp_q.size()), '0);
  endtask

  initial begin
    int d0;
    rst        = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    LLR_in     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({load_en, LOADADDRESS, load_done, busy, in_ready} == '0,
        "reset_outs",
        WW'({load_en, LOADADDRESS, load_done, busy, in_ready}), '0);
    chk(WRDOUT_VEC == '0, "reset_wrdout", WRDOUT_VEC, '0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(100, -1, 1'b0, 1'b0);
    run_frame(50, -1, 1'b0, 1'b0);

    in_valid = 1'b1;
    LLR_in   = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(in_ready == 1'b0 && busy == 1'b0, "idle_ignores_valid",
          WW'({in_ready, busy}), '0);
    end
    run_frame(100, -1, 1'b0, 1'b0);

    run_frame(60, -1, 1'b1, 1'b1);

    run_frame(100, 100, 1'b0, 1'b0);
    run_frame(100, -1, 1'b0, 1'b0);

    d0 = done_cnt;
    run_frame(100, -1, 1'b0, 1'b0);
    run_frame(70, -1, 1'b0, 1'b0);
    chk(done_cnt == d0 + 2, "two_frames_done",
        WW'(done_cnt - d0), WW'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
